// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle mul/div wait with timeout.
// Latency: stall/bubble/flush/start outputs are combinational from state and inputs (zero cycles).
// Backpressure: none; the pipeline obeys the stall/bubble/flush outputs. Optional HAZARD_PERF_EN adds perf counters.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_muldiv,
  input  logic        md_done,
  input  logic        ex_branch_taken,
  output logic        stall_if,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        md_start,
  output logic        md_timeout,
  output logic [1:0]  state,
  output logic [31:0] load_stall_cnt,
  output logic [31:0] md_stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MD_WAIT    = 2'b10
  } state_t;

  // Last MD_WAIT cycle index before the wait is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       timeout_hit;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign state = cur_state;

  // Next-state and control outputs; everything held low while reset is asserted.
  always_comb begin
    nxt_state   = cur_state;
    stall_if    = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    md_start    = 1'b0;
    timeout_hit = 1'b0;
    if (!rst) begin
      case (cur_state)
        RUN: begin
          if (ex_muldiv) begin
            md_start  = 1'b1;
            stall_if  = 1'b1;
            stall_ex  = 1'b1;
            nxt_state = MD_WAIT;
          end else if (ex_branch_taken) begin
            // Wrong-path instruction in ID is squashed, so its hazard is moot.
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
          end else if (load_use) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            nxt_state = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          nxt_state = RUN;
        end
        MD_WAIT: begin
          if (md_done) begin
            nxt_state = RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_hit = 1'b1;
            nxt_state   = RUN;
          end else begin
            stall_if = 1'b1;
            stall_ex = 1'b1;
          end
        end
        default: begin
          nxt_state = RUN;
        end
      endcase
    end
  end

  // State register, MD_WAIT cycle counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= RUN;
      wait_cnt   <= 8'd0;
      md_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state != MD_WAIT) begin
        wait_cnt <= 8'd0;
      end else if (nxt_state == MD_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        md_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Wrapping performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= 32'd0;
      md_stall_cnt   <= 32'd0;
      flush_cnt      <= 32'd0;
    end else begin
      if (cur_state == RUN && nxt_state == LOAD_STALL) begin
        load_stall_cnt <= load_stall_cnt + 32'd1;
      end
      if (stall_ex) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
      if (flush_if_id) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  assign load_stall_cnt = 32'd0;
  assign md_stall_cnt   = 32'd0;
  assign flush_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MD_TIMEOUT 64 and 4) share one stimulus stream.
// Expected outputs are pushed per cycle by the driver; a negedge monitor pops and compares.
// Counter expectations follow HAZARD_PERF_EN (zero when it is not defined).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        stall_if;
    logic        stall_ex;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        md_start;
    logic        md_timeout;
    logic [1:0]  state;
    logic [31:0] ls_cnt;
    logic [31:0] md_cnt;
    logic [31:0] fl_cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_muldiv = 1'b0, md_done = 1'b0, ex_branch_taken = 1'b0;

  logic        a_sif, a_sex, a_bub, a_fl, a_st, a_to;
  logic [1:0]  a_state;
  logic [31:0] a_ls, a_md, a_fc;
  logic        b_sif, b_sex, b_bub, b_fl, b_st, b_to;
  logic [1:0]  b_state;
  logic [31:0] b_ls, b_md, b_fc;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .md_done(md_done),
    .ex_branch_taken(ex_branch_taken), .stall_if(a_sif), .stall_ex(a_sex),
    .bubble_ex(a_bub), .flush_if_id(a_fl), .md_start(a_st), .md_timeout(a_to),
    .state(a_state), .load_stall_cnt(a_ls), .md_stall_cnt(a_md), .flush_cnt(a_fc)
  );

  pipeline_hazard_ctrl #(.MD_TIMEOUT(4)) dut_to4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .md_done(md_done),
    .ex_branch_taken(ex_branch_taken), .stall_if(b_sif), .stall_ex(b_sex),
    .bubble_ex(b_bub), .flush_if_id(b_fl), .md_start(b_st), .md_timeout(b_to),
    .state(b_state), .load_stall_cnt(b_ls), .md_stall_cnt(b_md), .flush_cnt(b_fc)
  );

  // Reference model: mode 0=running, 1=one-cycle load bubble, 2=waiting on mul/div.
  int          mode[2];
  int          waited[2];
  bit          to_flag[2];
  int unsigned n_ls[2], n_md[2], n_fl[2];
  int          limit[2] = '{64, 4};

  obs_t  q0[$];
  obs_t  q1[$];
  string phase = "reset";
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  function automatic void model_reset(int k);
    mode[k] = 0; waited[k] = 0; to_flag[k] = 1'b0;
    n_ls[k] = 0; n_md[k] = 0; n_fl[k] = 0;
  endfunction

  function automatic obs_t model_cycle(int k, bit r);
    obs_t e;
    bit   hz;
    e = '0;
    if (r) begin
      model_reset(k);
      return e;
    end
    e.md_timeout = to_flag[k];
    e.state      = 2'(mode[k]);
    e.ls_cnt     = PERF ? n_ls[k] : 32'd0;
    e.md_cnt     = PERF ? n_md[k] : 32'd0;
    e.fl_cnt     = PERF ? n_fl[k] : 32'd0;
    hz = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (mode[k] == 0) begin
      if (ex_muldiv) begin
        e.md_start = 1; e.stall_if = 1; e.stall_ex = 1;
        mode[k] = 2; waited[k] = 0;
      end else if (ex_branch_taken) begin
        e.flush_if_id = 1; e.bubble_ex = 1;
      end else if (hz) begin
        e.stall_if = 1; e.bubble_ex = 1;
        mode[k] = 1; n_ls[k]++;
      end
    end else if (mode[k] == 1) begin
      mode[k] = 0;
    end else begin
      if (md_done) begin
        mode[k] = 0;
      end else if (waited[k] + 1 == limit[k]) begin
        to_flag[k] = 1; mode[k] = 0;
      end else begin
        e.stall_if = 1; e.stall_ex = 1;
        waited[k]++;
      end
    end
    if (e.stall_ex) n_md[k]++;
    if (e.flush_if_id) n_fl[k]++;
    return e;
  endfunction

  task automatic step(input bit r, input bit mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input bit mdv,
                      input bit done, input bit br);
    @(posedge clk);
    #2;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; ex_muldiv = mdv; md_done = done;
    ex_branch_taken = br; rst = r;
    q0.push_back(model_cycle(0, r));
    q1.push_back(model_cycle(1, r));
  endtask

  task automatic idle(input int n, input bit done);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, done, 0);
  endtask

  function automatic void compare(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s phase=%s cyc=%0d actual=%h required=%h (sif,sex,bub,fl,st,to,state,ls,md,fl)",
               name, phase, cyc, act, exp);
    end
  endfunction

  // Monitor: outputs are valid every cycle; compare against the oldest expected entry.
  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0) compare("inst64", {a_sif, a_sex, a_bub, a_fl, a_st, a_to, a_state, a_ls, a_md, a_fc}, q0.pop_front());
    if (q1.size() > 0) compare("inst4", {b_sif, b_sex, b_bub, b_fl, b_st, b_to, b_state, b_ls, b_md, b_fc}, q1.pop_front());
  end

  initial begin
    model_reset(0);
    model_reset(1);

    phase = "reset";
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    idle(1, 0);

    phase = "load_use";
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 1, 7, 3, 7, 0, 1, 0, 0, 0);
    idle(2, 0);

    phase = "x0_nouse";
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 5, 5, 5, 0, 0, 0, 0, 0);
    idle(1, 0);

    phase = "branch";
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 1);
    idle(1, 0);

    phase = "muldiv5";
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4, 0);
    idle(1, 1);
    idle(2, 0);

    phase = "md_wait_ignores";
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 5, 5, 0, 1, 0, 1, 0, 1);
    idle(1, 1);
    idle(1, 0);

    phase = "timeout";
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(70, 0);
    idle(1, 1);
    idle(3, 0);

    phase = "reset_mid_wait";
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2, 0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    phase = "drain";
    checks++;
    if (q0.size() + q1.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0 pending", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, meaning the maximum number of cycles spent in MD_WAIT before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5  meaning the source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1  meaning the ID instruction actually reads that source.
REQ-006 SHALL have port ex_rd  input  5  meaning the destination register of the EX instruction.
REQ-007 SHALL have port ex_mem_read  input  1  meaning the EX instruction is a load.
REQ-008 SHALL have port ex_muldiv  input  1  meaning the EX instruction is a valid multi-cycle mul/div.
REQ-009 SHALL have port md_done  input  1  meaning the mul/div unit result is valid this cycle (pulse).
REQ-010 SHALL have port ex_branch_taken  input  1  meaning a taken branch or jump is resolved in EX.
REQ-011 SHALL have port stall_if  output  1  meaning hold the PC and the IF/ID register.
REQ-012 SHALL have port stall_ex  output  1  meaning hold the ID/EX register and the EX stage.
REQ-013 SHALL have port bubble_ex  output  1  meaning load a NOP into ID/EX at the next edge.
REQ-014 SHALL have port flush_if_id  output  1  meaning squash IF/ID at the next edge.
REQ-015 SHALL have port md_start  output  1  meaning a one-cycle start pulse to the mul/div unit.
REQ-016 SHALL have port md_timeout  output  1  meaning a sticky error flag set when MD_TIMEOUT expires.
REQ-017 SHALL have port state  output  2  meaning the current FSM state (RUN=00, LOAD_STALL=01, MD_WAIT=10).
REQ-018 SHALL have ports load_stall_cnt, md_stall_cnt, flush_cnt  output  32  meaning the performance counters.

Function
REQ-019 SHALL drive stall_if, stall_ex, bubble_ex, flush_if_id and md_start combinationally from state and the current inputs, with zero-cycle latency.
REQ-020 SHALL detect a load-use hazard as ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-021 SHALL, in RUN with ex_muldiv=1, assert md_start, stall_if and stall_ex, then enter MD_WAIT; this case has the highest priority.
REQ-022 SHALL, in RUN with ex_branch_taken=1 and ex_muldiv=0, assert flush_if_id and bubble_ex, keep stall_if=0, suppress any load-use stall, and stay in RUN.
REQ-023 SHALL, in RUN when a load-use hazard is detected and neither ex_muldiv nor ex_branch_taken is set, assert stall_if and bubble_ex and enter LOAD_STALL.
REQ-024 SHALL, in LOAD_STALL, assert no control outputs, suppress hazard detection, ignore ex_branch_taken and ex_muldiv, and return to RUN after exactly one cycle.
REQ-025 SHALL, in MD_WAIT, assert stall_if and stall_ex every cycle with md_done=0, and ignore ex_branch_taken and all hazards.
REQ-026 SHALL, in MD_WAIT on the cycle md_done=1, deassert all stalls that same cycle and return to RUN; md_start SHALL NOT re-pulse.
REQ-027 SHALL use an 8-bit MD_WAIT cycle counter that clears on MD_WAIT entry; if it reaches MD_TIMEOUT-1 with md_done=0, the block SHALL set md_timeout, deassert all stalls that cycle, and return to RUN.
REQ-028 SHALL treat md_done and a timeout in the same cycle as a normal completion, leaving md_timeout unchanged.
REQ-029 SHALL ignore md_done while in RUN or LOAD_STALL.
REQ-030 SHALL keep md_timeout sticky once set; only rst clears it.
REQ-031 SHALL never assert md_start in consecutive cycles.

Reset
REQ-032 SHALL, on rst assertion, immediately force state=RUN, clear the MD_WAIT counter, md_timeout and all perf counters, and drive all stall, bubble, flush and start outputs to 0, even mid-MD_WAIT.
REQ-033 SHALL, on the first clk edge after rst deasserts, evaluate in RUN with no history carried over.

Configuration
REQ-034 SHALL, with HAZARD_PERF_EN defined, count the following wrapping 32-bit quantities: load_stall_cnt increments on each LOAD_STALL entry, md_stall_cnt on each cycle stall_ex=1, and flush_cnt on each cycle flush_if_id=1.
REQ-035 SHALL, without HAZARD_PERF_EN, keep the counter ports present, tie them to 0, and infer no counter flops.

Verification
REQ-036 SHALL verify load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_if=1 and bubble_ex=1 for exactly one cycle, state 00->01->00, load_stall_cnt=1.
REQ-037 SHALL verify the x0 and no-use cases: ex_rd=0 or id_use_rs1=0 with matching registers -> no stall.
REQ-038 SHALL verify branch overriding load-use: the REQ-036 hazard plus ex_branch_taken=1 -> flush_if_id=1, bubble_ex=1, stall_if=0, state stays 00.
REQ-039 SHALL verify mul/div: ex_muldiv=1 with md_done pulsed 5 cycles later -> a one-cycle md_start, stall_ex=1 for 5 cycles then 0 on the md_done cycle, md_stall_cnt=5.
REQ-040 SHALL verify timeout: MD_TIMEOUT=4 and no md_done -> md_timeout=1 on the 4th MD_WAIT cycle, return to RUN, and the flag persists until rst.
REQ-041 SHALL verify reset mid-MD_WAIT: rst asserted asynchronously between edges -> all outputs 0 and state=00 before the next clk edge.
